// File: rtl/addsub_serial.sv
// addsub_serial: multi-cycle two's-complement adder/subtractor, CHUNK bits per clock
// with a start/busy/done handshake; carry ripples between chunks through cr.
module addsub_serial #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             dir,
   output logic [WIDTH-1:0] S,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             busy,
   output logic             done
);
   localparam int N = WIDTH / CHUNK;
   localparam int IW = N > 1 ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;
   logic [WIDTH-1:0] a_q, b_q, s_nx;
   logic [IW-1:0] idx;
   logic dir_q, cr, cin_msb;
   logic [CHUNK-1:0] a_c, b_c;
   logic [CHUNK:0] sum;
   always_comb begin
      a_c = a_q[idx*CHUNK +: CHUNK];
      b_c = b_q[idx*CHUNK +: CHUNK] ^ {CHUNK{dir_q}};
      sum = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, cr};
      // carry into the top bit of this chunk; only meaningful on the last chunk
      cin_msb = a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ sum[CHUNK-1];
      s_nx = S;
      s_nx[idx*CHUNK +: CHUNK] = sum[CHUNK-1:0];
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         a_q <= '0;
         b_q <= '0;
         dir_q <= 1'b0;
         idx <= '0;
         cr <= 1'b0;
         S <= '0;
         carry <= 1'b0;
         overflow <= 1'b0;
         zero <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            RUN: begin
               S <= s_nx;
               cr <= sum[CHUNK];
               idx <= idx + 1'b1;
               if (idx == LAST) begin
                  carry <= sum[CHUNK];
                  overflow <= sum[CHUNK] ^ cin_msb;
                  zero <= s_nx == '0;
                  busy <= 1'b0;
                  done <= 1'b1;
                  state <= DONE;
               end
            end
            default: begin
               if (start) begin
                  a_q <= A;
                  b_q <= B;
                  dir_q <= dir;
                  S <= '0;
                  idx <= '0;
                  cr <= dir;
                  busy <= 1'b1;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: directed 8-bit scenarios plus a randomized 16-bit sweep over
// CHUNK = 1, 4, 16, checked against an integer-arithmetic reference model.
module tb_addsub_serial;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic st8 = 1'b0, d8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0, s8;
   logic c8, v8, z8, busy8, done8;
   logic st16 = 1'b0, d16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic [15:0] s16 [3];
   logic c16 [3], v16 [3], z16 [3], busy16 [3], done16 [3];
   int n_chk = 0, n_err = 0;
   addsub_serial #(.WIDTH(8), .CHUNK(4)) u8 (.clk(clk), .rst(rst), .start(st8), .A(a8), .B(b8),
      .dir(d8), .S(s8), .carry(c8), .overflow(v8), .zero(z8), .busy(busy8), .done(done8));
   addsub_serial #(.WIDTH(16), .CHUNK(1)) u16a (.clk(clk), .rst(rst), .start(st16), .A(a16), .B(b16),
      .dir(d16), .S(s16[0]), .carry(c16[0]), .overflow(v16[0]), .zero(z16[0]), .busy(busy16[0]), .done(done16[0]));
   addsub_serial #(.WIDTH(16), .CHUNK(4)) u16b (.clk(clk), .rst(rst), .start(st16), .A(a16), .B(b16),
      .dir(d16), .S(s16[1]), .carry(c16[1]), .overflow(v16[1]), .zero(z16[1]), .busy(busy16[1]), .done(done16[1]));
   addsub_serial #(.WIDTH(16), .CHUNK(16)) u16c (.clk(clk), .rst(rst), .start(st16), .A(a16), .B(b16),
      .dir(d16), .S(s16[2]), .carry(c16[2]), .overflow(v16[2]), .zero(z16[2]), .busy(busy16[2]), .done(done16[2]));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   function automatic void ref_op(input int w, input longint a, input longint b, input bit d,
                                  output longint s, output bit c, output bit v);
      longint m = longint'(1) << w;
      longint sa = a >= m / 2 ? a - m : a;
      longint sb = b >= m / 2 ? b - m : b;
      longint r = d ? sa - sb : sa + sb;
      s = (((d ? a - b : a + b) % m) + m) % m;
      c = d ? a >= b : a + b >= m;
      v = r >= m / 2 || r < -(m / 2);
   endfunction
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic d, output int lat);
      @(negedge clk);
      a8 = a; b8 = b; d8 = d; st8 = 1'b1;
      @(posedge clk); #1 st8 = 1'b0;
      chk("busy8_after_start", busy8, 1);
      lat = 0;
      while (!done8 && lat < 20) begin
         @(posedge clk); #1 lat++;
      end
   endtask
   task automatic check8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic d, input int lat);
      longint s; bit c, v;
      ref_op(8, a, b, d, s, c, v);
      chk({tag, "_lat"}, lat, 2);
      chk({tag, "_S"}, s8, 32'(s));
      chk({tag, "_carry"}, c8, c);
      chk({tag, "_ovf"}, v8, v);
      chk({tag, "_zero"}, z8, s == 0);
   endtask
   initial begin
      int lat;
      int l16 [3];
      longint s; bit c, v;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_S", s8, 0);
      chk("rst_flags", {c8, v8, z8, busy8, done8}, 0);
      @(negedge clk) rst = 1'b0;
      op8(8'h7F, 8'h01, 1'b0, lat); check8("add_7f_01", 8'h7F, 8'h01, 1'b0, lat);
      chk("add_7f_01_busy_in_done", busy8, 0);
      op8(8'h00, 8'h01, 1'b1, lat); check8("sub_00_01", 8'h00, 8'h01, 1'b1, lat);
      op8(8'h80, 8'h01, 1'b1, lat); check8("sub_80_01", 8'h80, 8'h01, 1'b1, lat);
      // start pulsed mid-RUN must be ignored
      @(negedge clk);
      a8 = 8'h55; b8 = 8'hAB; d8 = 1'b0; st8 = 1'b1;
      @(posedge clk); #1 a8 = 8'h01; b8 = 8'h01; st8 = 1'b1;
      @(posedge clk); #1 st8 = 1'b0;
      chk("ign_no_early_done", done8, 0);
      @(posedge clk); #1;
      chk("ign_done", done8, 1);
      check8("add_55_ab", 8'h55, 8'hAB, 1'b0, 2);
      // back-to-back: start issued during the DONE cycle
      a8 = 8'h12; b8 = 8'h34; d8 = 1'b0; st8 = 1'b1;
      @(posedge clk); #1 st8 = 1'b0;
      chk("b2b_busy", busy8, 1);
      chk("b2b_single_done", done8, 0);
      chk("b2b_hold_carry", c8, 1);
      lat = 0;
      while (!done8 && lat < 20) begin
         @(posedge clk); #1 lat++;
      end
      check8("b2b_12_34", 8'h12, 8'h34, 1'b0, lat);
      @(posedge clk); #1;
      chk("done_one_cycle", done8, 0);
      chk("S_holds", s8, 8'h46);
      // asynchronous reset mid-RUN
      @(negedge clk);
      a8 = 8'hFF; b8 = 8'h0F; d8 = 1'b0; st8 = 1'b1;
      @(posedge clk); #1 st8 = 1'b0; rst = 1'b1;
      #1;
      chk("midrst_S", s8, 0);
      chk("midrst_flags", {c8, v8, z8, busy8, done8}, 0);
      @(negedge clk) rst = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         chk("midrst_no_done", done8, 0);
      end
      op8(8'h10, 8'h20, 1'b0, lat); check8("post_rst_10_20", 8'h10, 8'h20, 1'b0, lat);
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         a16 = $urandom_range(0, 7) == 0 ? 16'h8000 : 16'($urandom);
         b16 = $urandom_range(0, 7) == 0 ? 16'h7FFF : 16'($urandom);
         if ($urandom_range(0, 15) == 0) b16 = a16;
         d16 = 1'($urandom);
         st16 = 1'b1;
         @(posedge clk); #1 st16 = 1'b0;
         l16 = '{0, 0, 0};
         for (int t = 1; t <= 20 && (l16[0] == 0 || l16[1] == 0 || l16[2] == 0); t++) begin
            @(posedge clk); #1;
            for (int j = 0; j < 3; j++) if (done16[j] && l16[j] == 0) l16[j] = t;
         end
         ref_op(16, a16, b16, d16, s, c, v);
         for (int j = 0; j < 3; j++) begin
            chk($sformatf("w16_%0d_lat", j), l16[j], j == 0 ? 16 : j == 1 ? 4 : 1);
            chk($sformatf("w16_%0d_S", j), s16[j], 32'(s));
            chk($sformatf("w16_%0d_carry", j), c16[j], c);
            chk($sformatf("w16_%0d_ovf", j), v16[j], v);
            chk($sformatf("w16_%0d_zero", j), z16[j], s == 0);
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised, multi-cycle two's-complement adder/subtractor. It processes a WIDTH-bit operand pair CHUNK bits per clock, rippling the carry between chunks through a carry register. It is the clocked, width-generic successor to the combinational 4-bit ripple-carry adder/subtractor. A start/busy/done handshake lets the datapath controller trade latency for area by choosing CHUNK.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 2 and an integer multiple of CHUNK.
- CHUNK, 4, bits computed per cycle; 1 ≤ CHUNK ≤ WIDTH. Latency is N = WIDTH/CHUNK cycles.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only when busy=0.
- A  input  WIDTH  operand A; captured on an accepted start.
- B  input  WIDTH  operand B; captured on an accepted start.
- dir  input  1  mode, captured on an accepted start: 0 = A+B, 1 = A−B (B inverted, carry-in 1).
- S  output  WIDTH  result; holds its last value until the next accepted start.
- carry  output  1  carry out of the MSB. In subtract mode, 1 means no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  S == 0.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; result and flags are valid.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 → capture A, B and dir into internal registers; clear S; set chunk index to 0 and carry register to dir; go to RUN.
- RUN:
  - Each cycle, chunk i (bits i·CHUNK .. i·CHUNK+CHUNK−1) computes A_i + (B_i XOR {CHUNK{dir}}) + carry_reg.
  - Write the chunk sum into S at chunk i and update carry_reg.
  - On the last chunk (i = N−1), also register the carry into the MSB (needed for overflow), then go to DONE.
- DONE:
  - done=1 for exactly this cycle; carry, overflow and zero are updated on the transition into DONE.
  - start=1 in DONE is accepted exactly as in IDLE: back-to-back operation, next state RUN.
  - Otherwise the next state is IDLE.
- start while busy=1 is ignored, with no queuing.
- A, B and dir changing during RUN have no effect; only the captured copies are used.
- Width rules:
  - Arithmetic is modulo 2^WIDTH.
  - carry and overflow follow standard two's-complement definitions for the full WIDTH-bit operation, independent of CHUNK.
- CHUNK = WIDTH: N = 1 and RUN lasts a single cycle.
- Reset (asynchronous, any state, including mid-RUN):
  - state = IDLE; S = 0; carry = 0; overflow = 0; zero = 0; busy = 0; done = 0; internal registers = 0.
  - An interrupted operation produces no done.
  - The first edge after rst deasserts may accept start.

## Timing
- start sampled high at edge k (busy=0) → busy=1 from edge k to edge k+N.
- Chunks are computed on edges k+1 .. k+N.
- After edge k+N: state = DONE, done=1, busy=0, and S, carry, overflow and zero are all valid.
- After edge k+N+1: done=0. The outputs hold their values unless a new start was accepted at k+N+1.
- Maximum throughput is one result per N+1 cycles (start issued in DONE).
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, CHUNK=4; A=0x7F, B=0x01, dir=0 → done two cycles after the start edge; S=0x80, carry=0, overflow=1, zero=0.
- WIDTH=8, CHUNK=4:
  - A=0x00, B=0x01, dir=1 → S=0xFF, carry=0, overflow=0.
  - A=0x80, B=0x01, dir=1 → S=0x7F, carry=1, overflow=1.
- WIDTH=8, CHUNK=4; A=0x55, B=0xAB, dir=0 → S=0x00, carry=1, zero=1, overflow=0.
  - Then pulse start again during RUN with A=0x01, B=0x01 → ignored; only one done; result unchanged.
  - Then issue start in the DONE cycle → accepted; new result after N more cycles.
- Assert rst mid-RUN → all outputs 0 immediately (asynchronous); no done pulse.
  - After release, A=0x10, B=0x20, dir=0 → S=0x30.
- Parameter sweep: WIDTH=16 with CHUNK ∈ {1, 4, 16}; 1000 random operand/dir pairs each.
  - done exactly WIDTH/CHUNK cycles after start.
  - S, carry and overflow match the reference model (A ± B mod 2^16, signed-overflow rule).
